// File: rtl/stage_seq.sv
// stage_seq: multi-cycle instruction stage sequencer with memory wait timeout and halt/resume control.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   mem_rdata, mem_ack  memory read data and one-cycle access-complete strobe
//   needs_mem           decoder flag, sampled in EXECUTE
//   halt_insn           decoder flag, sampled in MEMSTORE
//   halt_req, resume    external halt request / resume pulses
//   stage               current stage (FETCH..HALTED)
//   mem_req             memory request level, mem_is_fetch marks instruction fetches
//   ir                  instruction register
//   retire              one-cycle pulse in MEMSTORE
//   instr_cnt           retired-instruction count (wraps)
//   bus_err             sticky memory-timeout flag
module stage_seq #(
    parameter int IR_W        = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] mem_rdata,
    input  logic            mem_ack,
    input  logic            needs_mem,
    input  logic            halt_insn,
    input  logic            halt_req,
    input  logic            resume,
    output logic [2:0]      stage,
    output logic            mem_req,
    output logic            mem_is_fetch,
    output logic [IR_W-1:0] ir,
    output logic            retire,
    output logic [15:0]     instr_cnt,
    output logic            bus_err
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMACCESS = 3'd3,
        MEMSTORE  = 3'd4,
        HALTED    = 3'd5
    } stage_t;
    stage_t          stage_q, stage_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            pend_q, pend_d;
    logic [7:0]      wait_q, wait_d;
    logic            mem_stage;
    logic            timeout;
    assign mem_stage = (stage_q == FETCH) || (stage_q == MEMACCESS);
    // an ack in the final allowed cycle wins over the timeout
    assign timeout   = mem_stage && !mem_ack && (wait_q == 8'(MEM_TIMEOUT));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            stage_q <= stage_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
        end
    end
    always_comb begin
        stage_d = stage_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q | timeout;
        // halt requests latch in any stage but HALTED; a clean resume clears them
        pend_d  = (stage_q == HALTED) ? (pend_q & ~(resume & ~halt_req)) : (pend_q | halt_req);
        // counting continues only while staying in a memory wait; every exit or entry clears it
        wait_d  = (mem_stage && !mem_ack && !timeout) ? wait_q + 8'd1 : 8'd0;
        case (stage_q)
            FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    stage_d = DECODE;
                end else if (timeout) begin
                    stage_d = HALTED;
                end
            end
            DECODE:    stage_d = EXECUTE;
            EXECUTE:   stage_d = needs_mem ? MEMACCESS : MEMSTORE;
            MEMACCESS: stage_d = mem_ack ? MEMSTORE : (timeout ? HALTED : MEMACCESS);
            MEMSTORE: begin
                cnt_d   = cnt_q + 16'd1;
                stage_d = (halt_insn || pend_q) ? HALTED : FETCH;
            end
            HALTED:    stage_d = (resume && !halt_req) ? FETCH : HALTED;
            default:   stage_d = FETCH;
        endcase
    end
    always_comb begin
        stage        = stage_q;
        mem_req      = mem_stage;
        mem_is_fetch = stage_q == FETCH;
        ir           = ir_q;
        retire       = stage_q == MEMSTORE;
        instr_cnt    = cnt_q;
        bus_err      = err_q;
    end
endmodule

// File: tb/tb_stage_seq.sv
// tb_stage_seq: self-checking bench for stage_seq with directed scenarios and a randomized reference-model run.
module tb_stage_seq;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata;
    logic        mem_ack, needs_mem, halt_insn, halt_req, resume;
    logic [2:0]  stage;
    logic        mem_req, mem_is_fetch, retire, bus_err;
    logic [15:0] ir, instr_cnt;
    int tests = 0;
    int fails = 0;
    logic [2:0]  m_stage;
    logic [15:0] m_ir, m_cnt;
    logic        m_err, m_pend;
    int          m_wait;

    stage_seq #(.IR_W(16), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .needs_mem(needs_mem), .halt_insn(halt_insn), .halt_req(halt_req), .resume(resume),
        .stage(stage), .mem_req(mem_req), .mem_is_fetch(mem_is_fetch), .ir(ir),
        .retire(retire), .instr_cnt(instr_cnt), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_in();
        mem_rdata = '0; mem_ack = 0; needs_mem = 0; halt_insn = 0; halt_req = 0; resume = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    // Reference: one clock of the stage rules, applied to the inputs present at that edge.
    task automatic model_step(input logic ack, input logic [15:0] rd, input logic nm,
                              input logic hi, input logic hr, input logic rs);
        logic [2:0] ns;
        ns = m_stage;
        if (m_stage == 0 || m_stage == 3) begin
            if (ack) begin
                if (m_stage == 0) begin m_ir = rd; ns = 1; end
                else ns = 4;
            end else if (m_wait == TO) begin
                m_err = 1; ns = 5;
            end else m_wait++;
        end else if (m_stage == 1) ns = 2;
        else if (m_stage == 2) ns = nm ? 3'd3 : 3'd4;
        else if (m_stage == 4) begin
            m_cnt = m_cnt + 16'd1;
            ns = (hi || m_pend) ? 3'd5 : 3'd0;
        end else if (rs && !hr) begin
            ns = 0; m_pend = 0;
        end
        if (hr && m_stage != 5) m_pend = 1;
        if (ns != m_stage) m_wait = 0;
        m_stage = ns;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_in();
        #1;
        tests++;
        if (stage !== 0 || ir !== 0 || instr_cnt !== 0 || bus_err !== 0 || retire !== 0) begin
            fails++;
            $display("FAIL reset_initial: stage=%0d ir=%h cnt=%h err=%b retire=%b, want all 0", stage, ir, instr_cnt, bus_err, retire);
        end
        mem_ack = 1; mem_rdata = 16'hFFFF;
        cyc(); cyc();
        tests++;
        if (stage !== 0 || ir !== 0) begin
            fails++;
            $display("FAIL reset_held: stage=%0d ir=%h, want 0 0", stage, ir);
        end
        clear_in();
        reset = 0;
        #1;
        tests++;
        if (mem_req !== 1 || mem_is_fetch !== 1) begin
            fails++;
            $display("FAIL reset_release_req: mem_req=%b fetch=%b, want 1 1", mem_req, mem_is_fetch);
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_seq [5] = '{0, 1, 2, 4, 0};
        int r = 0;
        do_reset();
        mem_rdata = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (stage !== exp_seq[k]) begin
                fails++;
                $display("FAIL basic_seq[%0d]: stage=%0d, want %0d", k, stage, exp_seq[k]);
            end
            if (retire) r++;
            mem_ack = (k == 0);
            cyc();
        end
        tests++;
        if (ir !== 16'h1234 || r != 1 || instr_cnt !== 1) begin
            fails++;
            $display("FAIL basic_result: ir=%h retires=%0d cnt=%0d, want 1234 1 1", ir, r, instr_cnt);
        end
    endtask

    task automatic test_memwait();
        logic [2:0] exp_seq [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        do_reset();
        needs_mem = 1;
        mem_rdata = 16'h00C3;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (stage !== exp_seq[k] || (exp_seq[k] == 3 && (mem_req !== 1 || mem_is_fetch !== 0))) begin
                fails++;
                $display("FAIL memwait_seq[%0d]: stage=%0d req=%b fetch=%b, want stage %0d", k, stage, mem_req, mem_is_fetch, exp_seq[k]);
            end
            mem_ack = (k == 0 || k == 6);
            cyc();
        end
        tests++;
        if (instr_cnt !== 1 || stage !== 0) begin
            fails++;
            $display("FAIL memwait_result: cnt=%0d stage=%0d, want 1 0", instr_cnt, stage);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (stage !== 0) begin
                fails++;
                $display("FAIL timeout_wait[%0d]: stage=%0d, want 0", k, stage);
            end
            cyc();
        end
        tests++;
        if (stage !== 5 || bus_err !== 1 || instr_cnt !== 0 || mem_req !== 0) begin
            fails++;
            $display("FAIL timeout_halt: stage=%0d err=%b cnt=%0d req=%b, want 5 1 0 0", stage, bus_err, instr_cnt, mem_req);
        end
        resume = 1;
        cyc();
        resume = 0;
        tests++;
        if (stage !== 0 || bus_err !== 1) begin
            fails++;
            $display("FAIL timeout_resume: stage=%0d err=%b, want 0 1", stage, bus_err);
        end
        do_reset();
        for (int k = 0; k < 4; k++) cyc();
        mem_ack = 1; mem_rdata = 16'hBEEF;
        cyc();
        mem_ack = 0;
        tests++;
        if (stage !== 1 || bus_err !== 0 || ir !== 16'hBEEF) begin
            fails++;
            $display("FAIL ack_at_timeout: stage=%0d err=%b ir=%h, want 1 0 beef", stage, bus_err, ir);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mem_ack = 1; mem_rdata = 16'h0005;
        cyc();
        mem_ack = 0; halt_req = 1;
        cyc();
        halt_req = 0;
        cyc();
        tests++;
        if (stage !== 4 || retire !== 1) begin
            fails++;
            $display("FAIL halt_retire: stage=%0d retire=%b, want 4 1", stage, retire);
        end
        cyc();
        tests++;
        if (stage !== 5 || instr_cnt !== 1) begin
            fails++;
            $display("FAIL halt_enter: stage=%0d cnt=%0d, want 5 1", stage, instr_cnt);
        end
        resume = 1; halt_req = 1;
        cyc();
        tests++;
        if (stage !== 5) begin
            fails++;
            $display("FAIL halt_resume_conflict: stage=%0d, want 5", stage);
        end
        halt_req = 0;
        cyc();
        resume = 0;
        tests++;
        if (stage !== 0) begin
            fails++;
            $display("FAIL halt_resume: stage=%0d, want 0", stage);
        end
        mem_ack = 1;
        cyc();
        mem_ack = 0;
        cyc(); cyc(); cyc();
        tests++;
        if (stage !== 0 || instr_cnt !== 2) begin
            fails++;
            $display("FAIL halt_cleared: stage=%0d cnt=%0d, want 0 2", stage, instr_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        mem_ack = 1; mem_rdata = 16'h00AA; halt_insn = 1;
        cyc();
        mem_ack = 0;
        cyc(); cyc();
        tests++;
        if (retire !== 1 || instr_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload: retire=%b cnt=%h, want 1 ffff", retire, instr_cnt);
        end
        cyc();
        halt_insn = 0;
        tests++;
        if (instr_cnt !== 16'h0000 || stage !== 5) begin
            fails++;
            $display("FAIL wrap_halt: cnt=%h stage=%0d, want 0000 5", instr_cnt, stage);
        end
    endtask

    task automatic test_async_reset();
        int r = 0;
        do_reset();
        mem_ack = 1; mem_rdata = 16'h5A5A;
        cyc();
        mem_ack = 0;
        cyc(); cyc(); cyc();
        mem_ack = 1; mem_rdata = 16'h7777; needs_mem = 1;
        cyc();
        mem_ack = 0;
        cyc(); cyc();
        tests++;
        if (stage !== 3 || instr_cnt !== 1 || ir !== 16'h7777) begin
            fails++;
            $display("FAIL async_setup: stage=%0d cnt=%0d ir=%h, want 3 1 7777", stage, instr_cnt, ir);
        end
        #2 reset = 1;
        #1;
        tests++;
        if (stage !== 0 || ir !== 0 || instr_cnt !== 0 || bus_err !== 0 || retire !== 0 || mem_req !== 1 || mem_is_fetch !== 1) begin
            fails++;
            $display("FAIL async_reset: stage=%0d ir=%h cnt=%0d err=%b retire=%b req=%b fetch=%b, want 0 0 0 0 0 1 1",
                     stage, ir, instr_cnt, bus_err, retire, mem_req, mem_is_fetch);
        end
        mem_ack = 1;
        cyc();
        reset = 0; mem_ack = 0;
        for (int k = 0; k < 3; k++) begin
            if (retire) r++;
            cyc();
        end
        tests++;
        if (r != 0 || instr_cnt !== 0) begin
            fails++;
            $display("FAIL async_no_retire: retires=%0d cnt=%0d, want 0 0", r, instr_cnt);
        end
    endtask

    task automatic test_random();
        logic er, ef, et;
        do_reset();
        m_stage = 0; m_ir = 0; m_cnt = 0; m_err = 0; m_pend = 0; m_wait = 0;
        for (int n = 0; n < 3000; n++) begin
            er = (m_stage == 0) || (m_stage == 3);
            ef = m_stage == 0;
            et = m_stage == 4;
            tests++;
            if (stage !== m_stage || ir !== m_ir || instr_cnt !== m_cnt || bus_err !== m_err ||
                mem_req !== er || mem_is_fetch !== ef || retire !== et) begin
                fails++;
                $display("FAIL random[%0d]: stage=%0d ir=%h cnt=%h err=%b req=%b fetch=%b ret=%b, want %0d %h %h %b %b %b %b",
                         n, stage, ir, instr_cnt, bus_err, mem_req, mem_is_fetch, retire,
                         m_stage, m_ir, m_cnt, m_err, er, ef, et);
            end
            mem_ack   = ($urandom_range(0, 99) < 55);
            mem_rdata = 16'($urandom);
            needs_mem = $urandom_range(0, 1) == 1;
            halt_insn = ($urandom_range(0, 99) < 10);
            halt_req  = ($urandom_range(0, 99) < 5);
            resume    = ($urandom_range(0, 99) < 30);
            model_step(mem_ack, mem_rdata, needs_mem, halt_insn, halt_req, resume);
            cyc();
        end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_memwait();
        test_timeout();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stage_seq.md
STAGE_SEQ -- requirements
Module: stage_seq

Interface
REQ-001 Parameter IR_W, default 16, instruction register width in bits.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles per memory access before bus error; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_rdata  input  IR_W  memory read data, valid when mem_ack=1.
REQ-006 mem_ack  input  1  memory access-complete strobe, one cycle.
REQ-007 needs_mem  input  1  decoder flag, sampled only in EXECUTE: the instruction needs a data-memory access.
REQ-008 halt_insn  input  1  decoder flag, sampled only in MEMSTORE: the instruction is HLT.
REQ-009 halt_req  input  1  external halt request pulse, legal in any stage.
REQ-010 resume  input  1  external resume pulse, honoured only in HALTED.
REQ-011 stage  output  3  current stage, type STAGE: FETCH=0, DECODE=1, EXECUTE=2, MEMACCESS=3, MEMSTORE=4, HALTED=5.
REQ-012 mem_req  output  1  memory request, level.
REQ-013 mem_is_fetch  output  1  1 = current request is an instruction fetch; 0 = data access.
REQ-014 ir  output  IR_W  instruction register.
REQ-015 retire  output  1  one-cycle pulse on the cycle stage=MEMSTORE.
REQ-016 instr_cnt  output  16  retired-instruction count.
REQ-017 bus_err  output  1  sticky memory-timeout flag.

Function
REQ-018 FETCH: mem_req=1, mem_is_fetch=1. mem_ack=1 -> ir<=mem_rdata, next stage DECODE. Otherwise remain in FETCH.
REQ-019 DECODE: exactly one cycle, then EXECUTE.
REQ-020 EXECUTE: exactly one cycle. needs_mem=1 -> MEMACCESS; needs_mem=0 -> MEMSTORE.
REQ-021 MEMACCESS: mem_req=1, mem_is_fetch=0. mem_ack=1 -> MEMSTORE. Otherwise remain in MEMACCESS.
REQ-022 MEMSTORE: exactly one cycle.
  - retire=1; instr_cnt increments by 1, wrapping 0xFFFF -> 0x0000.
  - Next stage HALTED if halt_insn=1 or halt_pend=1; otherwise FETCH.
REQ-023 HALTED: mem_req=0. resume=1 -> FETCH and halt_pend cleared. Otherwise remain in HALTED.
REQ-024 mem_req=0 in DECODE, EXECUTE, MEMSTORE and HALTED. mem_is_fetch=0 whenever mem_req=0.
REQ-025 mem_ack is ignored in any stage other than FETCH and MEMACCESS. ir holds its value outside the FETCH capture cycle.
REQ-026 Internal 8-bit wait_cnt:
  - cleared on entry to FETCH or MEMACCESS, and on mem_ack;
  - increments on each cycle in FETCH or MEMACCESS without mem_ack.
REQ-027 Timeout: wait_cnt==MEM_TIMEOUT with no mem_ack in that cycle -> bus_err<=1, next stage HALTED, no retire, ir unchanged. mem_ack arriving in the same cycle wins and there is no error.
REQ-028 bus_err clears only on reset; resume from HALTED does not clear it.
REQ-029 halt_req sets internal halt_pend in any stage except HALTED. An in-flight instruction always completes through MEMSTORE before halting; halt_req does not abort a memory wait.
REQ-030 halt_req=1 and resume=1 in the same HALTED cycle -> remain HALTED.
REQ-031 Instruction latency with no memory waits: 4 cycles without needs_mem (FETCH, DECODE, EXECUTE, MEMSTORE), 5 cycles with needs_mem.

Reset
REQ-032 While reset=1, asynchronously, independent of clk: stage=FETCH, ir=0, instr_cnt=0, bus_err=0, halt_pend=0, wait_cnt=0, retire=0.
REQ-033 mem_req is asserted in the first cycle after reset deasserts.
REQ-034 Reset asserted mid-wait or mid-instruction discards all progress; no retire pulse is produced.

Verification
REQ-035 Reset release, mem_ack in the 1st FETCH cycle with mem_rdata=0x1234, needs_mem=0 -> stage sequence 0,1,2,4,0; ir=0x1234; retire pulses once; instr_cnt=1.
REQ-036 needs_mem=1, MEMACCESS ack after 3 wait cycles -> stage sequence 0,1,2,3,3,3,3,4; mem_is_fetch=0 during MEMACCESS; instr_cnt=1.
REQ-037 MEM_TIMEOUT=4, no ack in FETCH -> after 5 FETCH cycles stage=5, bus_err=1, instr_cnt=0. resume -> FETCH with bus_err still 1.
REQ-038 halt_req pulsed in DECODE -> instruction retires, then stage=5. resume together with halt_req -> stays 5. resume alone -> FETCH.
REQ-039 Preload instr_cnt=0xFFFF and retire one instruction -> instr_cnt=0x0000. halt_insn=1 in MEMSTORE -> HALTED.
REQ-040 Assert reset asynchronously in MEMACCESS, between clock edges -> all outputs at their reset values before the next edge; no retire.
